// File: rtl/rs232_tx_sched.sv
// Round-robin scheduler sharing one rs232_send transmitter among NREQ byte streams.
// Each grant covers one packet, optionally prefixed by a channel-ID header byte.
module rs232_tx_sched #(
   parameter int         NREQ        = 4,
   parameter bit         HEADER_EN   = 1'b1,
   parameter logic [7:0] HEADER_BASE = 8'hA0,
   parameter int         MAX_PKT     = 64,
   localparam int        IDW         = $clog2(NREQ)
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [8*NREQ-1:0] req_data,
   input  logic [NREQ-1:0]   req_last,
   output logic [NREQ-1:0]   req_ready,
   output logic [7:0]        tx_data,
   output logic              tx_en,
   input  logic              tx_stb,
   output logic [IDW-1:0]    grant_id,
   output logic              busy,
   output logic              pkt_trunc,
   output logic [1:0]        state_dbg
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      HEADER  = 2'd1,
      PAYLOAD = 2'd2
   } state_t;

   state_t         state;
   logic [1:0]     rst_sync;
   logic           rst_n_i;
   logic [IDW-1:0] ptr;
   logic [IDW-1:0] ptr_nxt;
   logic [7:0]     cnt;
   logic [7:0]     cnt_nxt;
   logic [7:0]     hold_data;
   logic           hold_full;
   logic           slot_free;
   logic           take;
   logic           trunc_hit;
   logic [7:0]     sel_data;
   logic           arb_found;
   logic [IDW-1:0] arb_id;

   // Reset asserts asynchronously but releases on a clock edge.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) rst_sync <= 2'b00;
      else         rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_n_i = rst_sync[1];

   // Handshakes: a requester byte moves on a cycle with req_valid[i] & req_ready[i];
   // a held byte moves into the shifter on a cycle with tx_en & tx_stb.
   assign slot_free = !hold_full || tx_stb;
   assign take      = (state == PAYLOAD) && slot_free && req_valid[grant_id];
   assign sel_data  = req_data[{grant_id, 3'b000} +: 8];
   assign cnt_nxt   = cnt + 8'd1;
   assign trunc_hit = take && !req_last[grant_id] && (cnt_nxt == 8'(MAX_PKT));
   assign ptr_nxt   = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);

   always_comb begin
      req_ready           = '0;
      req_ready[grant_id] = take;
   end

   // Lowest offset from ptr wins, so scan downward and let the last hit stick.
   always_comb begin
      arb_found = 1'b0;
      arb_id    = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (req_valid[(int'(ptr) + k) % NREQ]) begin
            arb_found = 1'b1;
            arb_id    = IDW'((int'(ptr) + k) % NREQ);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state     <= IDLE;
         ptr       <= '0;
         grant_id  <= '0;
         cnt       <= '0;
         hold_data <= '0;
         hold_full <= 1'b0;
      end else begin
         if (tx_stb) hold_full <= 1'b0;
         case (state)
            IDLE: begin
               if (arb_found) begin
                  grant_id <= arb_id;
                  cnt      <= '0;
                  state    <= HEADER_EN ? HEADER : PAYLOAD;
               end
            end
            HEADER: begin
               if (slot_free) begin
                  hold_data <= HEADER_BASE + 8'(grant_id);
                  hold_full <= 1'b1;
                  state     <= PAYLOAD;
               end
            end
            PAYLOAD: begin
               if (take) begin
                  hold_data <= sel_data;
                  hold_full <= 1'b1;
                  cnt       <= cnt_nxt;
                  if (req_last[grant_id] || trunc_hit) begin
                     state <= IDLE;
                     ptr   <= ptr_nxt;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign tx_en     = hold_full;
   assign tx_data   = hold_data;
   assign busy      = (state != IDLE) || hold_full;
   assign pkt_trunc = trunc_hit;
   assign state_dbg = state;

endmodule
